offset_cal_scheduler: RTL and testbench
=======================================

# offset_cal_scheduler

Time-shares one zero-crossing peak/trough offset estimator across the three phase voltages (a, b, c) ahead of the sequence decomposer. Per-phase calibration requests are served round-robin: one window per grant, bounded by a timeout. The resulting DC offsets are held in a per-phase register bank and subtracted from every incoming sample, so the decomposer sees offset-free phases.

## Interface
Parameters:
- M, 14: sample width (signed two's complement).
- TIMEOUT, 4096: maximum number of sample strobes allowed per calibration window.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: reset, asynchronous, active-low; clears all state.
- sample_valid, in, 1: one-cycle strobe; va/vb/vc are valid together.
- va, vb, vc, in, M each: signed phase samples.
- cal_req, in, 3: level requests, bit0 = a, bit1 = b, bit2 = c.
- cal_enable, in, 1: 0 blocks new grants; an in-flight window still completes.
- busy, out, 1: a window is in progress (any state other than IDLE).
- sel, out, 2: phase being calibrated (0 = a, 1 = b, 2 = c); holds its last value when idle.
- offset_a, offset_b, offset_c, out, M each: current offsets.
- offset_valid, out, 3: set when that phase has completed at least one good calibration.
- cal_done, out, 1: one-cycle pulse when an offset is written.
- cal_err, out, 1: one-cycle pulse when a window is aborted.
- err_phase, out, 2: phase that was aborted; held until the next error.
- ya, yb, yc, out, M each: corrected samples.
- y_valid, out, 1: strobe accompanying ya/yb/yc.

## Operation
- FSM states: IDLE, GRANT, ARM, POS, NEG, UPDATE, ERR.
- IDLE → GRANT when cal_enable=1 and cal_req≠0.
- GRANT: round-robin pick. Search starts at the phase after the last granted one; the pointer is 2 after reset, so phase a has first priority. Latch sel, clear the timeout counter, set max=−2^(M−1) and min=2^(M−1)−1. Go to ARM.
- The tracked sample is v_sel. prev is the previous tracked sample, captured on each sample_valid and cleared to 0 in GRANT.
- All tracking transitions are evaluated only on sample_valid cycles:
  - ARM: on prev<0 and v≥0, go to POS and fold v into max.
  - POS: on prev≥0 and v<0, go to NEG and fold v into min; otherwise max = max(max, v).
  - NEG: on prev<0 and v≥0, go to UPDATE; otherwise min = min(min, v).
- UPDATE:
  - If max≥min: sum = max+min at M+1 bits, offset = sum >>> 1 (arithmetic shift, floor), truncated to M bits. Write the offset, set offset_valid[sel], pulse cal_done.
  - Otherwise go to ERR.
  - Advance the round-robin pointer to sel and return to IDLE.
- Timeout counter increments on each sample_valid in ARM, POS and NEG. When it reaches TIMEOUT, go to ERR.
- ERR: pulse cal_err, latch err_phase=sel, leave the offset and offset_valid unchanged, advance the pointer, return to IDLE.
- cal_req deasserting mid-window has no effect; the window runs to completion or timeout.
- Correction: on every sample_valid, y_x = sat_M(v_x − offset_x), computed at M+1 bits and saturated to [−2^(M−1), 2^(M−1)−1].
- The offset written in UPDATE applies starting with the next sample_valid.

## Timing
- Reset values: busy=0, sel=0, all offsets=0, offset_valid=0, cal_done=0, cal_err=0, err_phase=0, ya/yb/yc=0, y_valid=0, FSM in IDLE, pointer=2.
- Correction latency: 1 cycle. y_valid is sample_valid delayed by one cycle.
- Calibration latency:
  - IDLE→GRANT takes 1 cycle; GRANT→ARM takes 1 cycle.
  - The closing rising crossing is seen on sample_valid at edge N; UPDATE executes at edge N+1.
  - The offset and cal_done are visible after edge N+1. cal_done stays high for exactly 1 cycle.
- busy rises the cycle after the grant decision and falls the cycle after UPDATE or ERR.
- A sample_valid arriving during GRANT or UPDATE is still corrected but is not tracked.
- Reset asserted mid-window aborts the window with no cal_done or cal_err pulse.

## Structure
- Shared package holds: FSM state encoding, phase index constants (PH_A=0, PH_B=1, PH_C=2), and the saturate function.
- One natural sub-module: rr_arbiter3, a 3-request round-robin arbiter with a last-grant pointer. It is combinational grant logic plus a registered pointer.
- The correction path is three instances of a single subtract-saturate expression, not a sub-module.

## Test plan
- Reset default: hold rst=0, then release. All outputs are 0, busy=0, and y_x=v_x for every sample.
- Single calibration: cal_req=001, va = 1000 + 2000·sin, 64 samples per period. Result: offset_a=1000, offset_valid=001, one cal_done, then ya centred on 0 (peak ±2000).
- Round-robin: cal_req=111 held, with offsets 300, −500 and 0 on a, b, c. Grants are served in order a, b, c, a. The written offsets are 300, −500, 0.
- Timeout: TIMEOUT=100, cal_req=010, vb constant 500. After 100 strobes: cal_err pulse, err_phase=1, offset_b unchanged, busy returns to 0.
- Saturation and floor:
  - offset_a=−8192 and va=8191 gives ya=8191.
  - max=3, min=−4 gives offset −1 (floor).
- Mid-window events:
  - Drop cal_req in POS: the window still completes.
  - Assert rst in NEG: the offset is not written, no pulses occur, and the next grant goes to phase a.

Source files
------------

// File: rtl/offset_cal_scheduler_pkg.sv
// Shared definitions for the offset calibration scheduler: FSM encoding,
// phase indices and the signed saturation helper.
package offset_cal_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ARM,
        POS,
        NEG,
        UPDATE,
        ERR
    } state_t;

    localparam logic [1:0] PH_A = 2'd0;
    localparam logic [1:0] PH_B = 2'd1;
    localparam logic [1:0] PH_C = 2'd2;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/offset_cal_scheduler_arb.sv
// Three-way round-robin arbiter: combinational pick that starts searching
// after the last served phase, plus the registered last-grant pointer.
module rr_arbiter3
    import offset_cal_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       advance,
    input  logic [1:0] advance_to,
    output logic       grant_valid,
    output logic [1:0] grant
);

    logic [1:0] ptr;
    logic [1:0] order [3];

    // Pointer starts at phase c so phase a is first in line after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= PH_C;
        end else if (advance) begin
            ptr <= advance_to;
        end
    end

    always_comb begin
        order       = '{PH_A, PH_B, PH_C};
        grant_valid = 1'b0;
        grant       = PH_A;
        case (ptr)
            PH_A:    order = '{PH_B, PH_C, PH_A};
            PH_B:    order = '{PH_C, PH_A, PH_B};
            default: order = '{PH_A, PH_B, PH_C};
        endcase
        // Walk the priority list backwards so the highest-priority requester wins.
        for (int i = 2; i >= 0; i--) begin
            if (req[order[i]]) begin
                grant_valid = 1'b1;
                grant       = order[i];
            end
        end
    end

endmodule

// File: rtl/offset_cal_scheduler.sv
// Time-shares one zero-crossing peak/trough offset estimator across three
// phases and subtracts the per-phase offsets from every incoming sample.
module offset_cal_scheduler
    import offset_cal_scheduler_pkg::*;
#(
    parameter int M       = 14,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic signed [M-1:0] va,
    input  logic signed [M-1:0] vb,
    input  logic signed [M-1:0] vc,
    input  logic [2:0]          cal_req,
    input  logic                cal_enable,
    output logic                busy,
    output logic [1:0]          sel,
    output logic signed [M-1:0] offset_a,
    output logic signed [M-1:0] offset_b,
    output logic signed [M-1:0] offset_c,
    output logic [2:0]          offset_valid,
    output logic                cal_done,
    output logic                cal_err,
    output logic [1:0]          err_phase,
    output logic signed [M-1:0] ya,
    output logic signed [M-1:0] yb,
    output logic signed [M-1:0] yc,
    output logic                y_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
    localparam logic signed [M-1:0] SMIN = {1'b1, {(M-1){1'b0}}};
    localparam logic signed [M-1:0] SMAX = {1'b0, {(M-1){1'b1}}};

    state_t state, state_next;

    logic [2:0]          req_q;
    logic [CW-1:0]       cnt;
    logic signed [M-1:0] v, prev, max_q, min_q;
    logic signed [M:0]   sum;
    logic                rise, fall, tracking, tick, hit_timeout, good;
    logic                start, advance, write_off;
    logic                arb_valid;
    logic [1:0]          arb_grant;

    rr_arbiter3 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_q),
        .advance     (advance),
        .advance_to  (sel),
        .grant_valid (arb_valid),
        .grant       (arb_grant)
    );

    always_comb begin
        case (sel)
            PH_B:    v = vb;
            PH_C:    v = vc;
            default: v = va;
        endcase
    end

    assign rise        = prev[M-1] & ~v[M-1];
    assign fall        = ~prev[M-1] & v[M-1];
    assign tracking    = (state == ARM) || (state == POS) || (state == NEG);
    assign tick        = sample_valid && tracking;
    // The strobe that brings the count to TIMEOUT aborts the window.
    assign hit_timeout = tick && (cnt >= TLIM);
    assign sum         = {max_q[M-1], max_q} + {min_q[M-1], min_q};
    assign good        = max_q >= min_q;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        advance    = 1'b0;
        write_off  = 1'b0;
        case (state)
            IDLE: begin
                if (cal_enable && (cal_req != 3'b000)) begin
                    state_next = GRANT;
                    start      = 1'b1;
                end
            end
            GRANT:  state_next = arb_valid ? ARM : IDLE;
            ARM: begin
                if (hit_timeout)               state_next = ERR;
                else if (sample_valid && rise) state_next = POS;
            end
            POS: begin
                if (hit_timeout)               state_next = ERR;
                else if (sample_valid && fall) state_next = NEG;
            end
            NEG: begin
                if (hit_timeout)               state_next = ERR;
                else if (sample_valid && rise) state_next = UPDATE;
            end
            UPDATE: begin
                if (good) begin
                    state_next = IDLE;
                    advance    = 1'b1;
                    write_off  = 1'b1;
                end else begin
                    state_next = ERR;
                end
            end
            ERR: begin
                state_next = IDLE;
                advance    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Window tracking: the request snapshot taken on leaving IDLE keeps the
    // grant stable even if cal_req drops before GRANT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
            sel   <= PH_A;
            cnt   <= '0;
            prev  <= '0;
            max_q <= SMIN;
            min_q <= SMAX;
        end else begin
            if (start) begin
                req_q <= cal_req;
            end
            if (state == GRANT) begin
                if (arb_valid) begin
                    sel <= arb_grant;
                end
                cnt   <= '0;
                prev  <= '0;
                max_q <= SMIN;
                min_q <= SMAX;
            end else begin
                if (sample_valid) begin
                    prev <= v;
                end
                if (tick) begin
                    cnt <= cnt + CW'(1);
                end
                if (sample_valid) begin
                    case (state)
                        ARM: if (rise) max_q <= (v > max_q) ? v : max_q;
                        POS: begin
                            if (fall) min_q <= (v < min_q) ? v : min_q;
                            else      max_q <= (v > max_q) ? v : max_q;
                        end
                        NEG: if (!rise) min_q <= (v < min_q) ? v : min_q;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Offset bank and completion pulses; the offset is the floored midpoint.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset_a     <= '0;
            offset_b     <= '0;
            offset_c     <= '0;
            offset_valid <= '0;
            cal_done     <= 1'b0;
            cal_err      <= 1'b0;
            err_phase    <= PH_A;
        end else begin
            cal_done <= 1'b0;
            cal_err  <= 1'b0;
            if (write_off) begin
                cal_done <= 1'b1;
                case (sel)
                    PH_B: begin
                        offset_b        <= sum[M:1];
                        offset_valid[1] <= 1'b1;
                    end
                    PH_C: begin
                        offset_c        <= sum[M:1];
                        offset_valid[2] <= 1'b1;
                    end
                    default: begin
                        offset_a        <= sum[M:1];
                        offset_valid[0] <= 1'b1;
                    end
                endcase
            end
            if (state == ERR) begin
                cal_err   <= 1'b1;
                err_phase <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ya      <= '0;
            yb      <= '0;
            yc      <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= sample_valid;
            if (sample_valid) begin
                ya <= M'(saturate(32'(va) - 32'(offset_a), M));
                yb <= M'(saturate(32'(vb) - 32'(offset_b), M));
                yc <= M'(saturate(32'(vc) - 32'(offset_c), M));
            end
        end
    end

endmodule

// File: tb/tb_offset_cal_scheduler.sv
// Directed bench for offset_cal_scheduler: table-driven correction vectors
// plus hand-written calibration, round-robin, timeout and reset sequences.
module tb_offset_cal_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_valid;
    logic signed [13:0] va, vb, vc;
    logic [2:0]         cal_req;
    logic               cal_enable;
    logic               busy;
    logic [1:0]         sel;
    logic signed [13:0] offset_a, offset_b, offset_c;
    logic [2:0]         offset_valid;
    logic               cal_done, cal_err;
    logic [1:0]         err_phase;
    logic signed [13:0] ya, yb, yc;
    logic               y_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic sv;
        int   a, b, c;
        logic eyv;
        int   ea, eb, ec;
    } vec_t;

    vec_t vecs [5];

    offset_cal_scheduler #(.M(14), .TIMEOUT(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .va           (va),
        .vb           (vb),
        .vc           (vc),
        .cal_req      (cal_req),
        .cal_enable   (cal_enable),
        .busy         (busy),
        .sel          (sel),
        .offset_a     (offset_a),
        .offset_b     (offset_b),
        .offset_c     (offset_c),
        .offset_valid (offset_valid),
        .cal_done     (cal_done),
        .cal_err      (cal_err),
        .err_phase    (err_phase),
        .ya           (ya),
        .yb           (yb),
        .yc           (yc),
        .y_valid      (y_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic sv, input int a, input int b, input int c);
        sample_valid = sv;
        va = 14'(a);
        vb = 14'(b);
        vc = 14'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst          = 1'b0;
        sample_valid = 1'b0;
        cal_req      = 3'b000;
        cal_enable   = 1'b0;
        va = '0; vb = '0; vc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic int sine_sample(input int k);
        real r;
        r = 2000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
        return 1000 + ((r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5));
    endfunction

    function automatic int square(input int o, input int k);
        return o + (((k % 8) < 4) ? 1000 : -1000);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int k;
        int steps;
        int got;
        int n_done;
        int done_sel [4];
        int done_off [4];

        vecs[0] = '{1'b1, 100, -200, 300, 1'b1, 100, -200, 300};
        vecs[1] = '{1'b1, 8191, -8192, 0, 1'b1, 8191, -8192, 0};
        vecs[2] = '{1'b0, 5, 5, 5, 1'b0, 8191, -8192, 0};
        vecs[3] = '{1'b1, -1, 1, -8192, 1'b1, -1, 1, -8192};
        vecs[4] = '{1'b1, 0, 0, 0, 1'b1, 0, 0, 0};

        doReset();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset sel", sel, 0);
        checkOutput("reset offset_a", offset_a, 0);
        checkOutput("reset offset_b", offset_b, 0);
        checkOutput("reset offset_c", offset_c, 0);
        checkOutput("reset offset_valid", offset_valid, 0);
        checkOutput("reset cal_done", cal_done, 0);
        checkOutput("reset cal_err", cal_err, 0);
        checkOutput("reset err_phase", err_phase, 0);
        checkOutput("reset ya", ya, 0);
        checkOutput("reset y_valid", y_valid, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].sv, vecs[i].a, vecs[i].b, vecs[i].c);
            checkOutput($sformatf("vec%0d y_valid", i), y_valid, vecs[i].eyv);
            checkOutput($sformatf("vec%0d ya", i), ya, vecs[i].ea);
            checkOutput($sformatf("vec%0d yb", i), yb, vecs[i].eb);
            checkOutput($sformatf("vec%0d yc", i), yc, vecs[i].ec);
        end

        // Floor case: max=3, min=-4 must give -1.
        cal_enable = 1'b1;
        cal_req    = 3'b001;
        applyStimulus(1'b0, 0, 0, 0);
        cal_req = 3'b000;
        checkOutput("floor busy after grant", busy, 1);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("floor sel", sel, 0);
        applyStimulus(1'b1, -1, 0, 0);
        applyStimulus(1'b1, 3, 0, 0);
        applyStimulus(1'b1, -4, 0, 0);
        applyStimulus(1'b1, 0, 0, 0);
        checkOutput("floor done before update", cal_done, 0);
        checkOutput("floor busy in update", busy, 1);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("floor cal_done", cal_done, 1);
        checkOutput("floor offset_a", offset_a, -1);
        checkOutput("floor offset_valid", offset_valid, 1);
        checkOutput("floor busy after", busy, 0);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("floor done pulse width", cal_done, 0);

        // Sine on phase a; cal_req drops while the window sits in POS.
        cal_req = 3'b001;
        k       = 48;
        got     = 0;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b1, sine_sample(k), 0, 0);
            k++;
            if (k == 71) begin
                cal_req = 3'b000;
                checkOutput("pos drop busy", busy, 1);
            end
            if (cal_done) begin
                got = 1;
                break;
            end
        end
        checkOutput("sine done seen", got, 1);
        checkOutput("sine done timing", k, 125);
        checkOutput("sine offset_a", offset_a, 1000);
        checkOutput("sine offset_valid", offset_valid, 1);
        applyStimulus(1'b1, 3000, 0, 0);
        checkOutput("sine ya peak", ya, 2000);
        applyStimulus(1'b1, -1000, 0, 0);
        checkOutput("sine ya trough", ya, -2000);
        applyStimulus(1'b1, -8192, 0, 0);
        checkOutput("sine ya neg sat", ya, -8192);
        checkOutput("sine y_valid", y_valid, 1);

        // Round-robin from a fresh reset: expect a, b, c, a.
        doReset();
        checkOutput("rr reset offset_a", offset_a, 0);
        cal_enable = 1'b1;
        cal_req    = 3'b111;
        n_done     = 0;
        k          = 0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'b1, square(300, k), square(-500, k), square(0, k));
            k++;
            if (cal_done) begin
                done_sel[n_done] = int'(sel);
                case (sel)
                    2'd1:    done_off[n_done] = int'(offset_b);
                    2'd2:    done_off[n_done] = int'(offset_c);
                    default: done_off[n_done] = int'(offset_a);
                endcase
                n_done++;
                if (n_done == 4) begin
                    cal_enable = 1'b0;
                    cal_req    = 3'b000;
                    break;
                end
            end
        end
        checkOutput("rr windows", n_done, 4);
        if (n_done == 4) begin
            checkOutput("rr grant0", done_sel[0], 0);
            checkOutput("rr grant1", done_sel[1], 1);
            checkOutput("rr grant2", done_sel[2], 2);
            checkOutput("rr grant3", done_sel[3], 0);
            checkOutput("rr offset0", done_off[0], 300);
            checkOutput("rr offset1", done_off[1], -500);
            checkOutput("rr offset2", done_off[2], 0);
            checkOutput("rr offset3", done_off[3], 300);
        end
        applyStimulus(1'b1, 0, 8191, 0);
        checkOutput("rr busy idle", busy, 0);
        checkOutput("rr offset_valid", offset_valid, 7);
        checkOutput("sat yb pos", yb, 8191);
        checkOutput("sat ya", ya, -300);
        applyStimulus(1'b1, 0, -8192, 0);
        checkOutput("yb with offset", yb, -7692);

        // Timeout on phase b with a flat input.
        cal_enable = 1'b1;
        cal_req    = 3'b010;
        steps      = 0;
        for (int n = 1; n <= 200; n++) begin
            applyStimulus(1'b1, 0, 500, 0);
            steps = n;
            if (n == 2) begin
                cal_req = 3'b000;
                checkOutput("timeout sel", sel, 1);
            end
            if (cal_err) break;
        end
        checkOutput("timeout step", steps, 103);
        checkOutput("timeout cal_err", cal_err, 1);
        checkOutput("timeout err_phase", err_phase, 1);
        checkOutput("timeout offset_b", offset_b, -500);
        checkOutput("timeout offset_valid", offset_valid, 7);
        checkOutput("timeout busy", busy, 0);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("timeout err pulse width", cal_err, 0);

        // Reset while phase c sits in NEG.
        cal_req = 3'b110;
        applyStimulus(1'b0, 0, 0, 0);
        cal_req = 3'b000;
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("rstneg sel", sel, 2);
        applyStimulus(1'b1, 0, 0, -100);
        applyStimulus(1'b1, 0, 0, 200);
        applyStimulus(1'b1, 0, 0, -300);
        checkOutput("rstneg busy", busy, 1);
        rst = 1'b0;
        #2;
        checkOutput("rstneg busy cleared", busy, 0);
        checkOutput("rstneg offset_valid", offset_valid, 0);
        checkOutput("rstneg offset_c", offset_c, 0);
        checkOutput("rstneg cal_done", cal_done, 0);
        checkOutput("rstneg cal_err", cal_err, 0);
        @(posedge clk);
        #1;
        checkOutput("rstneg hold cal_done", cal_done, 0);
        checkOutput("rstneg hold cal_err", cal_err, 0);
        rst        = 1'b1;
        cal_enable = 1'b1;
        cal_req    = 3'b111;
        applyStimulus(1'b0, 0, 0, 0);
        cal_enable = 1'b0;
        cal_req    = 3'b000;
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("rstneg next grant", sel, 0);
        checkOutput("rstneg next busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
